// File: rtl/ddr5_cmd_decoder.sv
// Device-side DDR5 command bus decoder: reassembles ACT/RD/WR/PRE from CS_n/CA,
// tracks open banks and schedules the single RD/WR data window.
module ddr5_cmd_decoder #(
    parameter int RL    = 11,
    parameter int WL    = 8,
    parameter int BL    = 16,
    parameter int ROW_W = 16,
    parameter int COL_W = 6,
    localparam int BI_W = $clog2(BL)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cs_n_i,
    input  logic [13:0]      ca_i,
    output logic             cmd_valid_o,
    output logic [1:0]       cmd_type_o,
    output logic [1:0]       cmd_bg_o,
    output logic [1:0]       cmd_ba_o,
    output logic [ROW_W-1:0] cmd_row_o,
    output logic [COL_W-1:0] cmd_col_o,
    output logic             cmd_ap_o,
    output logic             cmd_partial_o,
    output logic             rd_beat_valid_o,
    output logic             wr_beat_valid_o,
    output logic [BI_W-1:0]  beat_idx_o,
    output logic [15:0]      bank_open_o,
    output logic             err_illegal_o,
    output logic             err_bank_o,
    output logic             err_overlap_o
);

    typedef enum logic [1:0] {CMD_ACT = 2'b00, CMD_RD = 2'b01, CMD_WR = 2'b10, CMD_PRE = 2'b11} cmd_e;
    typedef enum logic {ST_IDLE = 1'b0, ST_P2 = 1'b1} dec_state_e;
    typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_WAIT = 2'b01, TR_BURST = 2'b10} trk_state_e;

    localparam int LAT_MAX = (RL > WL) ? RL : WL;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    dec_state_e       state_q;
    cmd_e             p1_type_q;
    logic [3:0]       p1_bank_q;
    logic [3:0]       p1_row_lo_q;
    logic             cmd_valid_q;
    logic [1:0]       cmd_type_q;
    logic [3:0]       cmd_bank_q;
    logic [ROW_W-1:0] cmd_row_q;
    logic [COL_W-1:0] cmd_col_q;
    logic             cmd_ap_q;
    logic             cmd_partial_q;
    logic             err_illegal_q;
    logic             err_bank_q;
    logic             err_overlap_q;
    logic [15:0]      bank_open_q;
    logic [15:0]      bank_open_d;

    trk_state_e       trk_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             trk_rd_q;
    logic [BI_W-1:0]  beat_idx_q;
    logic             rd_beat_q;
    logic             wr_beat_q;
    logic             ap_pend_q;
    logic [3:0]       ap_bank_q;

    logic             p1_ok_s;
    cmd_e             p1_type_s;
    logic             done_s;
    cmd_e             done_type_s;
    logic [3:0]       done_bank_s;
    logic [ROW_W-1:0] done_row_s;
    logic [COL_W-1:0] done_col_s;
    logic             done_ap_s;
    logic             done_partial_s;
    logic             illegal_s;
    logic             latch_s;
    logic             burst_last_s;
    logic             busy_s;
    logic             err_bank_s;
    logic             err_overlap_s;
    logic             start_s;
    logic [CNT_W-1:0] start_lat_s;
    logic [15:0]      bank_sel_s;
    logic [15:0]      set_mask_s;
    logic [15:0]      clr_mask_s;
    logic [15:0]      ap_close_mask_s;
    logic             unused_ca_s;

    assign unused_ca_s = ^ca_i[13:12];

    // Phase-1 opcode classification of the current CA sample
    always_comb begin
        p1_ok_s   = 1'b1;
        p1_type_s = CMD_ACT;
        if (ca_i[1:0] == 2'b00) begin
            p1_type_s = CMD_ACT;
        end else begin
            case (ca_i[4:0])
                5'b11101: p1_type_s = CMD_RD;
                5'b01101: p1_type_s = CMD_WR;
                5'b11011: p1_type_s = CMD_PRE;
                default:  p1_ok_s   = 1'b0;
            endcase
        end
    end

    // Command completion: PRE completes on its only sample, others on phase 2
    always_comb begin
        done_s         = 1'b0;
        done_type_s    = CMD_ACT;
        done_bank_s    = 4'd0;
        done_row_s     = '0;
        done_col_s     = '0;
        done_ap_s      = 1'b0;
        done_partial_s = 1'b0;
        illegal_s      = 1'b0;
        latch_s        = 1'b0;
        if (!cs_n_i) begin
            illegal_s = (state_q == ST_P2) || !p1_ok_s;
            if (p1_ok_s && (p1_type_s == CMD_PRE)) begin
                done_s      = 1'b1;
                done_type_s = CMD_PRE;
                done_bank_s = ca_i[10:7];
            end else begin
                latch_s = p1_ok_s;
            end
        end else if (state_q == ST_P2) begin
            done_s      = 1'b1;
            done_type_s = p1_type_q;
            done_bank_s = p1_bank_q;
            case (p1_type_q)
                CMD_ACT: done_row_s = ROW_W'({ca_i[11:0], p1_row_lo_q});
                CMD_RD: begin
                    done_col_s = COL_W'(ca_i[7:2]);
                    done_ap_s  = ~ca_i[10];
                end
                CMD_WR: begin
                    done_col_s     = COL_W'(ca_i[7:2]);
                    done_ap_s      = ~ca_i[10];
                    done_partial_s = ~ca_i[11];
                end
                default: done_row_s = '0;
            endcase
        end else begin
            done_s = 1'b0;
        end
    end

    // Bank-state and tracker-occupancy checks for the completing command
    always_comb begin
        burst_last_s    = (trk_q == TR_BURST) && (beat_idx_q == BI_W'(BL - 1));
        busy_s          = (trk_q != TR_IDLE) && !burst_last_s;
        bank_sel_s      = 16'd1 << done_bank_s;
        ap_close_mask_s = (burst_last_s && ap_pend_q) ? (16'd1 << ap_bank_q) : 16'd0;
        start_lat_s     = (done_type_s == CMD_RD) ? CNT_W'(RL - 1) : CNT_W'(WL - 1);
        err_bank_s      = 1'b0;
        err_overlap_s   = 1'b0;
        start_s         = 1'b0;
        set_mask_s      = 16'd0;
        clr_mask_s      = 16'd0;
        if (done_s) begin
            case (done_type_s)
                CMD_ACT: begin
                    // an auto-precharge still pending on this bank blocks re-activation
                    err_bank_s = bank_open_q[done_bank_s] || (ap_pend_q && (ap_bank_q == done_bank_s));
                    set_mask_s = err_bank_s ? 16'd0 : bank_sel_s;
                end
                CMD_PRE: clr_mask_s = bank_sel_s;
                default: begin
                    err_bank_s    = !bank_open_q[done_bank_s];
                    err_overlap_s = busy_s;
                    start_s       = bank_open_q[done_bank_s] && !busy_s;
                end
            endcase
        end else begin
            start_s = 1'b0;
        end
        bank_open_d = (bank_open_q & ~ap_close_mask_s & ~clr_mask_s) | set_mask_s;
    end

    // Command decoder FSM, bank table and registered command/error outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            p1_type_q     <= CMD_ACT;
            p1_bank_q     <= 4'd0;
            p1_row_lo_q   <= 4'd0;
            cmd_valid_q   <= 1'b0;
            cmd_type_q    <= 2'b00;
            cmd_bank_q    <= 4'd0;
            cmd_row_q     <= '0;
            cmd_col_q     <= '0;
            cmd_ap_q      <= 1'b0;
            cmd_partial_q <= 1'b0;
            err_illegal_q <= 1'b0;
            err_bank_q    <= 1'b0;
            err_overlap_q <= 1'b0;
            bank_open_q   <= 16'd0;
        end else begin
            state_q <= latch_s ? ST_P2 : ST_IDLE;
            if (latch_s) begin
                p1_type_q   <= p1_type_s;
                p1_bank_q   <= ca_i[10:7];
                p1_row_lo_q <= ca_i[6:3];
            end
            cmd_valid_q   <= done_s;
            cmd_type_q    <= done_type_s;
            cmd_bank_q    <= done_bank_s;
            cmd_row_q     <= done_row_s;
            cmd_col_q     <= done_col_s;
            cmd_ap_q      <= done_ap_s;
            cmd_partial_q <= done_partial_s;
            err_illegal_q <= illegal_s;
            err_bank_q    <= err_bank_s;
            err_overlap_q <= err_overlap_s;
            bank_open_q   <= bank_open_d;
        end
    end

    // Burst tracker FSM: latency wait, beat counting and auto-precharge bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trk_q      <= TR_IDLE;
            wait_cnt_q <= '0;
            trk_rd_q   <= 1'b0;
            beat_idx_q <= '0;
            rd_beat_q  <= 1'b0;
            wr_beat_q  <= 1'b0;
            ap_pend_q  <= 1'b0;
            ap_bank_q  <= 4'd0;
        end else begin
            case (trk_q)
                TR_IDLE: begin
                    if (start_s) begin
                        trk_q      <= TR_WAIT;
                        wait_cnt_q <= start_lat_s;
                        trk_rd_q   <= (done_type_s == CMD_RD);
                    end
                end
                TR_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        trk_q      <= TR_BURST;
                        beat_idx_q <= '0;
                        rd_beat_q  <= trk_rd_q;
                        wr_beat_q  <= !trk_rd_q;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                    end
                end
                TR_BURST: begin
                    if (burst_last_s) begin
                        rd_beat_q <= 1'b0;
                        wr_beat_q <= 1'b0;
                        if (start_s) begin
                            trk_q      <= TR_WAIT;
                            wait_cnt_q <= start_lat_s;
                            trk_rd_q   <= (done_type_s == CMD_RD);
                        end else begin
                            trk_q <= TR_IDLE;
                        end
                    end else begin
                        beat_idx_q <= beat_idx_q + BI_W'(1);
                    end
                end
                default: trk_q <= TR_IDLE;
            endcase
            if (start_s) begin
                ap_pend_q <= done_ap_s;
                ap_bank_q <= done_bank_s;
            end else if (burst_last_s) begin
                ap_pend_q <= 1'b0;
            end
        end
    end

    assign cmd_valid_o     = cmd_valid_q;
    assign cmd_type_o      = cmd_type_q;
    assign cmd_bg_o        = cmd_bank_q[3:2];
    assign cmd_ba_o        = cmd_bank_q[1:0];
    assign cmd_row_o       = cmd_row_q;
    assign cmd_col_o       = cmd_col_q;
    assign cmd_ap_o        = cmd_ap_q;
    assign cmd_partial_o   = cmd_partial_q;
    assign rd_beat_valid_o = rd_beat_q;
    assign wr_beat_valid_o = wr_beat_q;
    assign beat_idx_o      = beat_idx_q;
    assign bank_open_o     = bank_open_q;
    assign err_illegal_o   = err_illegal_q;
    assign err_bank_o      = err_bank_q;
    assign err_overlap_o   = err_overlap_q;

endmodule

// File: tb/tb_ddr5_cmd_decoder.sv
// Scoreboard bench for ddr5_cmd_decoder: directed scenarios plus randomized traffic
// against a command-level reference model of bank state and burst timing.
module tb_ddr5_cmd_decoder;
    localparam int RL   = 11;
    localparam int WL   = 8;
    localparam int BL   = 16;
    localparam int NCYC = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic [13:0] ca = 14'd0;
    logic        cmd_valid, cmd_ap, cmd_partial, rd_beat_valid, wr_beat_valid;
    logic [1:0]  cmd_type, cmd_bg, cmd_ba;
    logic [15:0] cmd_row, bank_open;
    logic [5:0]  cmd_col;
    logic [3:0]  beat_idx;
    logic        err_illegal, err_bank, err_overlap;

    ddr5_cmd_decoder dut (
        .clk_i(clk), .rst_i(rst), .cs_n_i(cs_n), .ca_i(ca),
        .cmd_valid_o(cmd_valid), .cmd_type_o(cmd_type), .cmd_bg_o(cmd_bg), .cmd_ba_o(cmd_ba),
        .cmd_row_o(cmd_row), .cmd_col_o(cmd_col), .cmd_ap_o(cmd_ap), .cmd_partial_o(cmd_partial),
        .rd_beat_valid_o(rd_beat_valid), .wr_beat_valid_o(wr_beat_valid), .beat_idx_o(beat_idx),
        .bank_open_o(bank_open), .err_illegal_o(err_illegal), .err_bank_o(err_bank),
        .err_overlap_o(err_overlap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int        k;
        bit        valid;
        bit [1:0]  typ;
        bit [3:0]  bank;
        bit [15:0] row;
        bit [5:0]  col;
        bit        ap;
        bit        partial;
        bit        e_ill;
        bit        e_bank;
        bit        e_ovl;
    } exp_t;

    exp_t      q[$];
    bit        exp_rd[NCYC];
    bit        exp_wr[NCYC];
    int        exp_idx[NCYC];
    bit [15:0] exp_open[NCYC];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    bit [15:0] m_open = 16'd0;
    bit        m_p2 = 1'b0;
    int        m_ptype = 0;
    bit [3:0]  m_pbank = 4'd0;
    bit [3:0]  m_prowlo = 4'd0;
    int        m_first = 0;
    int        m_last = -1;
    bit        m_ap = 1'b0;
    bit [3:0]  m_apbank = 4'd0;
    int        last_k = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    // Reference model: what the device must report for the command bus sample at edge k
    task automatic model_edge(input int k, input bit csn, input logic [13:0] c);
        exp_t     e;
        bit       done;
        int       t;
        bit [3:0] b;
        int       lat;
        e = '{default: 0};
        e.k = k;
        done = 1'b0;
        t = 0;
        b = 4'd0;
        if (!csn) begin
            if (m_p2) e.e_ill = 1'b1;
            m_p2 = 1'b0;
            if (c[1:0] == 2'b00) begin
                m_p2 = 1'b1; m_ptype = 0; m_pbank = c[10:7]; m_prowlo = c[6:3];
            end else if (c[4:0] == 5'b11101) begin
                m_p2 = 1'b1; m_ptype = 1; m_pbank = c[10:7];
            end else if (c[4:0] == 5'b01101) begin
                m_p2 = 1'b1; m_ptype = 2; m_pbank = c[10:7];
            end else if (c[4:0] == 5'b11011) begin
                done = 1'b1; t = 3; b = c[10:7];
            end else begin
                e.e_ill = 1'b1;
            end
        end else if (m_p2) begin
            m_p2 = 1'b0;
            done = 1'b1;
            t = m_ptype;
            b = m_pbank;
            if (t == 0) begin
                e.row = {c[11:0], m_prowlo};
            end else begin
                e.col = c[7:2];
                e.ap = !c[10];
                e.partial = (t == 2) && !c[11];
            end
        end
        if (done) begin
            e.valid = 1'b1;
            e.typ = 2'(t);
            e.bank = b;
            if (t == 0) begin
                e.e_bank = m_open[b] || (m_ap && m_apbank == b);
            end else if (t != 3) begin
                e.e_bank = !m_open[b];
                e.e_ovl = (m_last >= k);
            end
        end
        if (m_ap && k == m_last + 1) begin
            m_open[m_apbank] = 1'b0;
            m_ap = 1'b0;
        end
        if (done) begin
            if (t == 0 && !e.e_bank) m_open[b] = 1'b1;
            if (t == 3) m_open[b] = 1'b0;
            if ((t == 1 || t == 2) && !e.e_bank && !e.e_ovl) begin
                lat = (t == 1) ? RL : WL;
                m_first = k + lat;
                m_last = k + lat + BL - 1;
                for (int i = 0; i < BL; i++) begin
                    exp_rd[m_first + i] = (t == 1);
                    exp_wr[m_first + i] = (t == 2);
                    exp_idx[m_first + i] = i;
                end
                m_ap = e.ap;
                m_apbank = b;
            end
        end
        exp_open[k] = m_open;
        if (e.valid || e.e_ill) q.push_back(e);
    endtask

    task automatic model_reset();
        m_open = 16'd0; m_p2 = 1'b0; m_ap = 1'b0; m_last = -1; m_first = 0;
        q.delete();
        for (int i = 0; i < NCYC; i++) begin
            exp_rd[i] = 1'b0; exp_wr[i] = 1'b0; exp_idx[i] = 0; exp_open[i] = 16'd0;
        end
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        int   k;
        if (mon_en) begin
            k = cyc;
            chk("rd_beat_valid", rd_beat_valid, exp_rd[k]);
            chk("wr_beat_valid", wr_beat_valid, exp_wr[k]);
            if (exp_rd[k] || exp_wr[k]) chk("beat_idx", beat_idx, exp_idx[k]);
            chk("bank_open", bank_open, exp_open[k]);
            if (q.size() > 0 && q[0].k == k) begin
                e = q.pop_front();
                chk("cmd_valid", cmd_valid, e.valid);
                chk("err_illegal", err_illegal, e.e_ill);
                chk("err_bank", err_bank, e.e_bank);
                chk("err_overlap", err_overlap, e.e_ovl);
                if (e.valid) begin
                    chk("cmd_type", cmd_type, e.typ);
                    chk("cmd_bank", {cmd_bg, cmd_ba}, e.bank);
                    chk("cmd_row", cmd_row, e.row);
                    chk("cmd_col", cmd_col, e.col);
                    chk("cmd_ap", cmd_ap, e.ap);
                    chk("cmd_partial", cmd_partial, e.partial);
                end
            end else begin
                chk("quiet", {cmd_valid, err_illegal, err_bank, err_overlap}, 4'b0000);
            end
        end
    end

    task automatic step(input bit csn, input logic [13:0] c);
        @(negedge clk);
        cs_n = csn;
        ca = c;
        last_k = cyc + 1;
        model_edge(last_k, csn, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 14'($urandom));
    endtask

    function automatic logic [13:0] p1(input int t, input logic [3:0] b, input logic [3:0] rlo);
        logic [13:0] c;
        c = 14'($urandom);
        c[10:7] = b;
        case (t)
            0: begin c[1:0] = 2'b00; c[6:3] = rlo; end
            1: c[4:0] = 5'b11101;
            2: c[4:0] = 5'b01101;
            default: c[4:0] = 5'b11011;
        endcase
        return c;
    endfunction

    function automatic logic [13:0] p2(input int t, input logic [15:0] row, input logic [5:0] col,
                                       input bit apb, input bit wrpb);
        logic [13:0] c;
        c = 14'($urandom);
        if (t == 0) begin
            c[11:0] = row[15:4];
        end else begin
            c[7:2] = col;
            c[10] = apb;
            c[11] = wrpb;
        end
        return c;
    endfunction

    function automatic logic [13:0] illegal_ca(input logic [3:0] b);
        logic [13:0] c;
        c = 14'($urandom);
        c[10:7] = b;
        while (c[1:0] == 2'b00 || c[4:0] == 5'b11101 || c[4:0] == 5'b01101 || c[4:0] == 5'b11011)
            c[4:0] = 5'($urandom);
        return c;
    endfunction

    task automatic issue(input int t, input logic [3:0] b, input logic [15:0] row,
                         input logic [5:0] col, input bit apb, input bit wrpb);
        step(1'b0, p1(t, b, row[3:0]));
        if (t != 3) step(1'b1, p2(t, row, col, apb, wrpb));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_bank_open", bank_open, 16'd0);
        chk("rst_beats", {rd_beat_valid, wr_beat_valid, beat_idx}, 6'd0);
        chk("rst_errs", {err_illegal, err_bank, err_overlap}, 3'd0);
        rst = 1'b0;
        #1 mon_en = 1'b1;

        issue(0, 4'd6, 16'hABCD, 6'd0, 1'b1, 1'b1);
        idle(1);
        issue(1, 4'd6, 16'h0000, 6'd5, 1'b1, 1'b1);
        idle(32);
        issue(0, 4'd3, 16'h1234, 6'd0, 1'b1, 1'b1);
        issue(2, 4'd3, 16'h0000, 6'd17, 1'b0, 1'b0);
        idle(30);
        issue(1, 4'd9, 16'h0000, 6'd2, 1'b1, 1'b1);
        issue(3, 4'd9, 16'h0000, 6'd0, 1'b1, 1'b1);
        idle(2);
        step(1'b0, p1(0, 4'd2, 4'd7));
        issue(3, 4'd5, 16'h0000, 6'd0, 1'b1, 1'b1);
        idle(3);
        issue(0, 4'd0, 16'h4321, 6'd0, 1'b1, 1'b1);
        issue(1, 4'd0, 16'h0000, 6'd9, 1'b1, 1'b1);
        idle(2);
        issue(1, 4'd0, 16'h0000, 6'd33, 1'b1, 1'b1);
        idle(40);

        issue(0, 4'd1, 16'h5A5A, 6'd0, 1'b1, 1'b1);
        issue(1, 4'd1, 16'h0000, 6'd3, 1'b1, 1'b1);
        while (last_k < m_first + 7) idle(1);
        @(negedge clk);
        #2 mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_rd_beat", rd_beat_valid, 1'b0);
        chk("arst_beat_idx", beat_idx, 4'd0);
        chk("arst_bank_open", bank_open, 16'd0);
        chk("arst_cmd_valid", cmd_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1 mon_en = 1'b1;
        issue(0, 4'd1, 16'h0F0F, 6'd0, 1'b1, 1'b1);
        idle(3);

        for (int n = 0; n < 300; n++) begin
            int       r;
            int       t;
            logic [3:0] b;
            r = $urandom_range(0, 99);
            t = $urandom_range(0, 3);
            b = 4'($urandom_range(0, 5));
            if (r < 5) begin
                step(1'b0, illegal_ca(b));
            end else if (r < 10) begin
                step(1'b0, p1($urandom_range(0, 2), 4'($urandom_range(0, 5)), 4'($urandom)));
                issue(t, b, 16'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                issue(t, b, 16'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 9) == 0) idle(25);
            else idle($urandom_range(0, 3));
        end

        idle(40);
        @(negedge clk);
        #1 mon_en = 1'b0;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
